wrr_pkt_arbiter: RTL
====================

# wrr_pkt_arbiter

Packet-aware weighted round-robin arbiter that shares one downstream beat channel among N requesters. Each requester gets a programmable per-round packet budget (weight), and a grant is held for a whole multi-beat packet. The block sits between the client request ports and a shared datapath or bus master. It replaces single-cycle grant arbitration wherever packets must not be interleaved.

## Interface
- `N`, 4, number of requesters (2..16).
- `MAX_WEIGHT`, 15, largest programmable weight; `WW = $clog2(MAX_WEIGHT+1)`.
- `IDW`, derived, `$clog2(N)`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_weight`  in  N*WW  packed per-client weight, client i at `[i*WW +: WW]`; 0 disables the client.
- `req`  in  N  per-client request; held high from request through the last accepted beat.
- `req_last`  in  N  per-client last-beat flag, qualified by the client's grant.
- `ack`  in  1  downstream accepts the current beat (`grant_valid & ack` = beat transfer).
- `grant`  out  N  one-hot registered grant.
- `grant_id`  out  IDW  index of granted client; valid when `grant_valid`.
- `grant_valid`  out  1  `|grant`.

## Operation
- States: IDLE (no grant) and LOCKED (grant held to one client).
- Per-client credit register, width WW; reset 0.
- Eligible(i) = `req[i]` & (`cfg_weight[i]` != 0) & (credit_eff[i] != 0).
- credit_eff = credit after any same-cycle end-of-packet decrement.
- Replenish: when requests are pending from enabled clients but none is eligible, all credits load `cfg_weight` in that cycle. Arbitration in the same cycle uses the reloaded values.
- Weights are sampled only at replenish. A weight change mid-round takes effect at the next replenish.
- Arbitration evaluation happens in IDLE, or in LOCKED in the cycle of `ack & req_last[grant_id]`.
- Pick: round-robin among eligible clients, starting at `ptr`. Priority order is `ptr`, `ptr+1`, …, wrapping mod N.
- On pick: grant registers the winner, state goes LOCKED, `ptr` becomes winner+1 mod N.
- End of packet (`ack & req_last[grant_id]` while LOCKED): the granted client's credit decrements by 1 (saturating at 0). If no winner is picked, state returns to IDLE and grant clears.
- Credits decrement only at end of packet. Beats within a packet cost nothing.
- No eligible and no pending enabled request: stay or return to IDLE, and credits hold.
- Disabled clients (weight 0) are never granted and never trigger replenish.

## Timing
- Reset values: `grant`=0, `grant_id`=0, `grant_valid`=0, state IDLE, `ptr`=0, all credits 0.
- The first request after reset triggers a replenish in the cycle it is seen.
- Latency: request seen in IDLE at cycle t → grant at t+1.
- Back-to-back packets: end of packet at t → next winner's grant at t+1. No idle bubble.
- While LOCKED, grant holds regardless of `req` or `ack`.
- A `req` drop while LOCKED is a protocol violation: assert in simulation, grant holds.
- Single-beat packet: `req_last` high on the first accepted beat ends the packet in that cycle.
- `ack` without `grant_valid` is ignored.
- `req_last` from non-granted clients is ignored.
- Reset mid-packet: grant drops on the next edge with `rst_n` low, and all state reinitialises. No credit survives reset.

## Structure
- Package `wrr_pkt_pkg`:
  - `wrr_state_e` enum (IDLE, LOCKED).
  - Helper function for modulo-N index increment.
- Sub-module `wrr_pkt_rr_pick`:
  - Combinational, parameter N.
  - Inputs: eligible vector and pointer.
  - Outputs: one-hot winner, winner index, any-valid.
  - Implemented with a double-width mask-and-priority scheme.
- Top level holds the credit registers, replenish logic, pointer, state and output registers.

## Test plan
- **Reset then single request:** N=4, weights 1/1/1/1, `req`=0001, single-beat packets, `ack`=1.
  - Required: `grant`=0001 on the cycle after `req`, and `grant_id`=0.
  - Required: a replenish occurs on the first cycle.
- **Weighted share:** weights 3/1/0/2, all requests constant, 1-beat packets, `ack`=1.
  - Required grant sequence per round: 0,1,3,0,3,0 (rotating), then repeat.
  - Required: client 2 is never granted.
- **Packet lock:** client 1 sends 4 beats with `ack` toggling 1010…, while client 2 requests throughout.
  - Required: `grant` stays 0010 until the 4th acked beat with `req_last`.
  - Required: `grant`=0100 on the next cycle, with no idle cycle between.
- **Replenish with disabled client:** weights 0/2/0/0, only `req[1]`, 5 one-beat packets.
  - Required: a grant every cycle.
  - Required: credits go 2→1→0, reload to 2, and the sequence repeats.
- **Weight change mid-round:** client 0 weight changed 3→1 after its first packet.
  - Required: client 0 still receives 3 packets this round and 1 packet in the next round.
- **Reset mid-packet:** `rst_n` low for 1 cycle during a 3-beat packet.
  - Required: `grant`=0 on the next edge, `ptr`=0, and credits 0.
  - Required: re-arbitration after release gives client 0 priority.

Source files
------------

// File: rtl/wrr_pkt_arbiter_pkg.sv
// wrr_pkt_pkg
// Shared types and helpers for the packet-aware weighted round-robin arbiter.
//   wrr_state_e : arbiter lock state (IDLE / LOCKED)
//   inc_mod     : index increment with wrap at n
package wrr_pkt_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } wrr_state_e;

  function automatic int unsigned inc_mod(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wrr_pkt_arbiter_if.sv
// wrr_pkt_arbiter_if
// Client request / grant bundle shared by all requesters and the downstream.
//   req, req_last : per-client request and last-beat flag
//   ack           : downstream accepts the current beat
//   grant         : one-hot grant, grant_id its index, grant_valid = |grant
// Modports: master drives requests (clients / bench), slave is the arbiter.
interface wrr_pkt_arbiter_if #(
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   req_last;
  logic           ack;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;

  modport master (
    output req, req_last, ack,
    input  grant, grant_id, grant_valid
  );

  modport slave (
    input  req, req_last, ack,
    output grant, grant_id, grant_valid
  );
endinterface

// File: rtl/wrr_pkt_rr_pick.sv
// wrr_pkt_rr_pick
// Combinational round-robin picker: first set bit of elig at or after ptr,
// wrapping mod N.
//   elig       in  N    candidate vector
//   ptr        in  IDW  highest-priority index
//   win_onehot out N    one-hot winner
//   win_id     out IDW  winner index
//   win_any    out 1    at least one candidate
module wrr_pkt_rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   elig,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   win_onehot,
  output logic [IDW-1:0] win_id,
  output logic           win_any
);

  logic [N-1:0]   below_ptr;
  logic [2*N-1:0] dbl;
  logic           found;
  logic [IDW-1:0] idx;

  // Lower copy has indices below ptr masked off; the unmasked upper copy
  // supplies the wrap-around candidates, so a plain lowest-bit search works.
  always_comb begin
    below_ptr = (N'(1) << ptr) - N'(1);
    dbl       = {elig, elig & ~below_ptr};
    found     = 1'b0;
    idx       = '0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!found && dbl[j]) begin
        found = 1'b1;
        idx   = IDW'(j % N);
      end
    end
  end

  assign win_any    = found;
  assign win_id     = idx;
  assign win_onehot = found ? (N'(1) << idx) : '0;

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// wrr_pkt_arbiter
// Packet-aware weighted round-robin arbiter. A grant is held for a whole
// packet; each client may win cfg_weight packets per round before credits
// are reloaded.
//   clk         in  clock
//   rst_n       in  synchronous active-low reset
//   cfg_weight  in  N*WW packed weights, client i at [i*WW +: WW], 0 = disabled
//   bus         slave modport of wrr_pkt_arbiter_if (req/req_last/ack in,
//               grant/grant_id/grant_valid out)
module wrr_pkt_arbiter
  import wrr_pkt_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int MAX_WEIGHT = 15,
  localparam int WW         = $clog2(MAX_WEIGHT + 1),
  localparam int IDW        = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*WW-1:0]   cfg_weight,
  wrr_pkt_arbiter_if.slave  bus
);

  wrr_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [WW-1:0]  credit_q   [N];
  logic [WW-1:0]  credit_dec [N];
  logic [WW-1:0]  credit_eff [N];
  logic [WW-1:0]  weight     [N];

  logic [N-1:0]   enabled, elig_pre, elig;
  logic           eop, eval, pending, replenish;
  logic [N-1:0]   win_onehot;
  logic [IDW-1:0] win_id;
  logic           win_any;

  assign eop  = (state_q == LOCKED) && bus.ack && bus.req_last[grant_id_q];
  assign eval = (state_q == IDLE) || eop;

  // Credits seen by arbitration: end-of-packet decrement first, then a
  // reload if nobody with a pending request has credit left.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      weight[i]     = cfg_weight[i*WW +: WW];
      enabled[i]    = (weight[i] != '0);
      credit_dec[i] = credit_q[i];
      if (eop && (IDW'(i) == grant_id_q) && (credit_q[i] != '0))
        credit_dec[i] = credit_q[i] - WW'(1);
      elig_pre[i]   = bus.req[i] && enabled[i] && (credit_dec[i] != '0);
    end
    pending   = |(bus.req & enabled);
    replenish = eval && pending && (elig_pre == '0);
    for (int i = 0; i < N; i++) begin
      credit_eff[i] = replenish ? weight[i] : credit_dec[i];
      elig[i]       = bus.req[i] && enabled[i] && (credit_eff[i] != '0);
    end
  end

  wrr_pkt_rr_pick #(.N(N)) u_pick (
    .elig       (elig),
    .ptr        (ptr_q),
    .win_onehot (win_onehot),
    .win_id     (win_id),
    .win_any    (win_any)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    if (eval) begin
      if (win_any) begin
        state_d    = LOCKED;
        grant_d    = win_onehot;
        grant_id_d = win_id;
        ptr_d      = IDW'(inc_mod(32'(win_id), N));
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      for (int i = 0; i < N; i++) credit_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      for (int i = 0; i < N; i++) credit_q[i] <= credit_eff[i];
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = |grant_q;

  // A granted client must keep req high until its last beat is accepted.
  req_held_a : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == LOCKED) |-> bus.req[grant_id_q]);

endmodule
